// File: rtl/bus_dmx_feeder_if.sv
// Handshake and demux-side signals for bus_dmx_feeder.
// The master drives the upstream words and auto_mode; the slave (the feeder) drives everything else.
interface bus_dmx_feeder_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [2:0]   in_addr;
    logic         auto_mode;
    logic [2:0]   addr;
    logic [N-1:0] x;
    logic         out_active;
    logic         frame_done;

    modport master (
        output in_valid, in_data, in_addr, auto_mode,
        input  in_ready, addr, x, out_active, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_addr, auto_mode,
        output in_ready, addr, x, out_active, frame_done
    );
endinterface

// File: rtl/bus_dmx_feeder.sv
// Buffers routed words in a small FIFO and presents each on x/addr for HOLD cycles,
// optionally overriding the destination with a round-robin slot counter.
module bus_dmx_feeder #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_dmx_feeder_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [0:0] {StIdle, StDrive} state_e;

    logic [N-1:0] mem_data [DEPTH];
    logic [2:0]   mem_addr [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         empty, full, push, pop;

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] x_q, x_d;
    logic [2:0]   addr_q, addr_d;
    logic [2:0]   slot_q, slot_d;
    logic         word_auto_q, word_auto_d;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = bus.in_valid && !full;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        addr_d      = addr_q;
        word_auto_d = word_auto_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) pop = 1'b1;
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                        x_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            state_d     = StDrive;
            cnt_d       = CW'(HOLD - 1);
            x_d         = mem_data[rptr_q[AW-1:0]];
            addr_d      = bus.auto_mode ? slot_q : mem_addr[rptr_q[AW-1:0]];
            word_auto_d = bus.auto_mode;
        end
        slot_d = '0;
        if (bus.auto_mode) slot_d = pop ? slot_q + 3'd1 : slot_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q[AW-1:0]] <= bus.in_data;
            mem_addr[wptr_q[AW-1:0]] <= bus.in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            x_q         <= '0;
            addr_q      <= '0;
            slot_q      <= '0;
            word_auto_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            word_auto_q <= word_auto_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.x          = x_q;
    assign bus.addr       = addr_q;
    assign bus.out_active = (state_q == StDrive);
    assign bus.frame_done = (state_q == StDrive) && (cnt_q == '0) && word_auto_q
                            && (addr_q == 3'd7);
endmodule
